// File: rtl/ak4619_tdm_target_if.sv
// Signal bundle between an AK4619 TDM controller (master) and the codec-side target (slave).
interface ak4619_tdm_target_if #(
   parameter int W = 16
);
   logic                lrck;
   logic                sdin;
   logic                sdout;
   logic signed [W-1:0] sample_in0;
   logic signed [W-1:0] sample_in1;
   logic signed [W-1:0] sample_in2;
   logic signed [W-1:0] sample_in3;
   logic signed [W-1:0] sample_out0;
   logic signed [W-1:0] sample_out1;
   logic signed [W-1:0] sample_out2;
   logic signed [W-1:0] sample_out3;
   logic                sample_valid;
   logic                locked;
   logic                sync_err;

   modport slave (
      input  lrck, sdin,
      input  sample_in0, sample_in1, sample_in2, sample_in3,
      output sdout,
      output sample_out0, sample_out1, sample_out2, sample_out3,
      output sample_valid, locked, sync_err
   );

   modport master (
      output lrck, sdin,
      output sample_in0, sample_in1, sample_in2, sample_in3,
      input  sdout,
      input  sample_out0, sample_out1, sample_out2, sample_out3,
      input  sample_valid, locked, sync_err
   );
endinterface

// File: rtl/ak4619_tdm_target.sv
// Codec-side end of the 4-slot TDM link: LRCK framing/lock, SDIN deserialiser, SDOUT serialiser.
// Define AK4619_TARGET_LOOPBACK_EN to echo received DAC words back on SDOUT instead of sample_in.
module ak4619_tdm_target #(
   parameter int W         = 16,
   parameter int SLOT_BITS = 32
) (
   input logic                clk,
   input logic                rst,
   ak4619_tdm_target_if.slave bus
);
   localparam int FRAME = 4 * SLOT_BITS;
   localparam int PW    = $clog2(FRAME);
   localparam int WW    = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {HUNT, ARMED, LOCK} lock_state_t;
   typedef logic [3:0][W-1:0] quad_t;

   lock_state_t   state, state_nxt;
   logic          lrck_prev;
   logic [PW-1:0] pos, pos_inc, p, p_next;
   logic [W-2:0]  rx_sr;
   logic [W-1:0]  rx_word;
   quad_t         rx_buf, rx_buf_nxt, tx_buf, tx_buf_nxt, tx_src, out_q;
   logic          sdout_q, valid_q, err_q;
   logic          fall, rise, wrap, err, commit, tx_bit;
   logic [1:0]    slot, slot_n;
   int            bpos, bpos_n;

   // pos holds last cycle's position; a fall edge forces the current one to 0
   assign fall    = lrck_prev & ~bus.lrck;
   assign rise    = ~lrck_prev & bus.lrck;
   assign wrap    = (pos == PW'(FRAME - 1));
   assign pos_inc = wrap ? '0 : pos + PW'(1);
   assign p       = fall ? '0 : pos_inc;
   assign p_next  = (p == PW'(FRAME - 1)) ? '0 : p + PW'(1);

   always_comb begin
      slot   = 2'(int'(p) / SLOT_BITS);
      bpos   = int'(p) % SLOT_BITS;
      slot_n = 2'(int'(p_next) / SLOT_BITS);
      bpos_n = int'(p_next) % SLOT_BITS;
   end

   // HUNT waits for the first fall after reset, which only arms the frame check
   always_comb begin
      state_nxt = state;
      err       = 1'b0;
      case (state)
         HUNT:    if (fall) state_nxt = ARMED;
         ARMED:   if (fall && wrap) state_nxt = LOCK;
         LOCK: begin
            if ((fall && !wrap) || (!fall && wrap) ||
                (rise && p != PW'(2 * SLOT_BITS))) begin
               state_nxt = ARMED;
               err       = 1'b1;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HUNT;
      else     state <= state_nxt;
   end

   always_comb begin
      rx_word    = {rx_sr, bus.sdin};
      rx_buf_nxt = rx_buf;
      if (bpos == W - 1) rx_buf_nxt[slot] = rx_word;
   end

   // Commit reads rx_buf_nxt so a slot-3 word finishing on the last bit is not lost
   always_comb begin
`ifdef AK4619_TARGET_LOOPBACK_EN
      tx_src = rx_buf_nxt;
`else
      tx_src = {bus.sample_in3, bus.sample_in2, bus.sample_in1, bus.sample_in0};
`endif
      commit     = (state == LOCK) && (state_nxt == LOCK) && (p == PW'(FRAME - 1));
      tx_buf_nxt = commit ? tx_src : tx_buf;
      tx_bit     = 1'b0;
      if (bpos_n < W) tx_bit = tx_buf_nxt[slot_n][WW'(W - 1 - bpos_n)];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lrck_prev <= 1'b0;
         pos       <= '0;
         rx_sr     <= '0;
         rx_buf    <= '0;
         tx_buf    <= '0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         sdout_q   <= 1'b0;
      end else begin
         lrck_prev <= bus.lrck;
         pos       <= p;
         if (bpos < W) rx_sr <= rx_word[W-2:0];
         rx_buf    <= rx_buf_nxt;
         tx_buf    <= tx_buf_nxt;
         valid_q   <= commit;
         err_q     <= err;
         // sdout is preloaded with the bit for the next position, silenced off-lock
         sdout_q   <= (state_nxt == LOCK) & tx_bit;
         if (commit) out_q <= rx_buf_nxt;
      end
   end

   assign bus.sdout        = sdout_q;
   assign bus.sample_out0  = out_q[0];
   assign bus.sample_out1  = out_q[1];
   assign bus.sample_out2  = out_q[2];
   assign bus.sample_out3  = out_q[3];
   assign bus.sample_valid = valid_q;
   assign bus.locked       = (state == LOCK);
   assign bus.sync_err     = err_q;
endmodule

// File: tb/tb_ak4619_tdm_target.sv
// Scoreboard bench for ak4619_tdm_target: directed TDM frames, lock loss/reacquire, mid-frame reset.
module tb_ak4619_tdm_target;
   typedef logic [3:0][15:0] quad_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ak4619_tdm_target_if #(.W(16)) bus ();
   ak4619_tdm_target #(.W(16), .SLOT_BITS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0, n_pass = 0;
   quad_t rxq[$], txq[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic quad_t q(input logic [15:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   // Monitor: compare on sample_valid, then capture the following frame of SDOUT if expected
   int n_valid = 0, n_err = 0, n_leak = 0, cap_n = -1;
   logic [127:0] cap;
   quad_t cap_exp, got_q, exp_q;
   initial forever begin
      @(negedge clk);
      if (bus.sync_err) n_err++;
      if (!bus.locked && bus.sdout) n_leak++;
      if (bus.sample_valid) begin
         n_valid++;
         got_q = {bus.sample_out3, bus.sample_out2, bus.sample_out1, bus.sample_out0};
         if (rxq.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
         else begin
            exp_q = rxq.pop_front();
            for (int i = 0; i < 4; i++)
               check($sformatf("sample_out%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            if (txq.size() != 0) begin
               cap_exp = txq.pop_front();
               cap_n   = 0;
            end
         end
      end
      if (cap_n >= 0) begin
         cap[cap_n[6:0]] = bus.sdout;
         cap_n++;
         if (cap_n == 128) begin
            int pad_bad = 0;
            for (int s = 0; s < 4; s++) begin
               logic [15:0] w;
               for (int b = 0; b < 16; b++) w[15-b] = cap[s*32+b];
               check($sformatf("sdout_slot%0d", s), 32'(w), 32'(cap_exp[s]));
            end
            for (int i = 0; i < 128; i++) if ((i % 32) >= 16 && cap[i]) pad_bad++;
            check("sdout_pad", pad_bad, 0);
            cap_n = -1;
         end
      end
   end

   task automatic set_in(input quad_t v);
      bus.sample_in0 = v[0];
      bus.sample_in1 = v[1];
      bus.sample_in2 = v[2];
      bus.sample_in3 = v[3];
   endtask

   // One bit clock of controller output at frame position p; bits past the word are junk
   task automatic cyc(input int p, input quad_t w);
      int s = p / 32;
      int b = p % 32;
      @(negedge clk);
      bus.lrck = (p >= 64);
      bus.sdin = (b < 16) ? w[s][15-b] : 1'b1;
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_out0"}, 32'($unsigned(bus.sample_out0)), 32'd0);
      check({tag, "_out1"}, 32'($unsigned(bus.sample_out1)), 32'd0);
      check({tag, "_out2"}, 32'($unsigned(bus.sample_out2)), 32'd0);
      check({tag, "_out3"}, 32'($unsigned(bus.sample_out3)), 32'd0);
      check({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
      check({tag, "_locked"}, 32'(bus.locked), 32'd0);
      check({tag, "_sync_err"}, 32'(bus.sync_err), 32'd0);
      check({tag, "_sdout"}, 32'(bus.sdout), 32'd0);
   endtask

   quad_t wA, wB, wC, wD, wE, wF, wG, wH, wJ, sinC, exp_tx;

   initial begin
      wA   = q(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      wB   = q(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
      wC   = q(16'h0F0F, 16'hF0F0, 16'h1111, 16'hEEEE);
      wD   = q(16'h0001, 16'h0002, 16'h0003, 16'h0004);
      wE   = q(16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000);
      wF   = q(16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA);
      wG   = q(16'hC001, 16'h0FF0, 16'h8001, 16'h7FFE);
      wH   = q(16'h9999, 16'h6666, 16'h3C3C, 16'hC3C3);
      wJ   = q(16'h4321, 16'hFEDC, 16'h0080, 16'h0100);
      sinC = q(16'hA5A5, 16'h0001, 16'h8000, 16'h5A5A);
`ifdef AK4619_TARGET_LOOPBACK_EN
      exp_tx = wC;
`else
      exp_tx = sinC;
`endif
      rst = 1'b1;
      bus.lrck = 1'b1;
      bus.sdin = 1'b0;
      set_in('0);
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // A: first fall only arms
      for (int p = 0; p < 128; p++) begin
         cyc(p, wA);
         if (p == 100) check("lock_a_unlocked", 32'(bus.locked), 32'd0);
      end
      // B: second fall locks, commit at p=127
      rxq.push_back(wB);
      for (int p = 0; p < 128; p++) begin
         cyc(p, wB);
         if (p == 0) check("lock_b_p0", 32'(bus.locked), 32'd0);
         if (p == 1) check("lock_b_p1", 32'(bus.locked), 32'd1);
      end
      // C: sample_in held across commit, transmitted during D
      set_in(sinC);
      rxq.push_back(wC);
      for (int p = 0; p < 128; p++) begin
         cyc(p, wC);
         if (p == 5) txq.push_back(exp_tx);
      end
      check("sync_quiet", n_err, 0);
      rxq.push_back(wD);
      for (int p = 0; p < 128; p++) begin
         cyc(p, wD);
         if (p == 0) set_in('0);
      end
      // E: lrck glitch high at p=49, falls again at 50
      for (int p = 0; p < 49; p++) cyc(p, wE);
      @(negedge clk);
      bus.lrck = 1'b1;
      for (int p = 0; p < 128; p++) begin
         cyc(p, wF);
         if (p == 0) begin
            check("glitch_sync_err", 32'(bus.sync_err), 32'd1);
            check("glitch_locked", 32'(bus.locked), 32'd0);
            check("glitch_sdout", 32'(bus.sdout), 32'd0);
         end
         if (p == 1) check("glitch_sync_err_1cyc", 32'(bus.sync_err), 32'd0);
         if (p == 100) check("glitch_still_unlocked", 32'(bus.locked), 32'd0);
      end
      check("sync_err_count_glitch", n_err, 1);
      rxq.push_back(wG);
      for (int p = 0; p < 128; p++) begin
         cyc(p, wG);
         if (p == 1) check("relock", 32'(bus.locked), 32'd1);
      end
      // H: reset at p=20
      for (int p = 0; p < 128; p++) begin
         cyc(p, wH);
         if (p == 20) begin
            rst = 1'b1;
            #1;
            check_outs_zero("midrst");
         end
         if (p == 21) rst = 1'b0;
      end
      for (int p = 0; p < 128; p++) begin
         cyc(p, wA);
         if (p == 1) check("rst_first_fall_unlocked", 32'(bus.locked), 32'd0);
      end
      rxq.push_back(wJ);
      for (int p = 0; p < 128; p++) begin
         cyc(p, wJ);
         if (p == 1) check("rst_relock", 32'(bus.locked), 32'd1);
      end
      for (int p = 0; p < 10; p++) cyc(p, wA);
      repeat (2) @(negedge clk);

      check("valid_count", n_valid, 5);
      check("rxq_drained", rxq.size(), 0);
      check("txq_drained", txq.size(), 0);
      check("capture_done", cap_n, -1);
      check("sync_err_total", n_err, 1);
      check("sdout_off_lock", n_leak, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ak4619_tdm_target.md
Name: ak4619_tdm_target

Overview:
- Codec-side (target) end of the 4-slot, 16-bit TDM audio link used by the AK4619 driver.
- Runs on the bit clock, tracks LRCK framing, and deserialises SDIN into 4 DAC words.
- Serialises 4 ADC words onto SDOUT.
- Used as a synthesizable codec stand-in for loopback/bring-up and as the DUT-side model in driver benches.

Parameters:
- W, 16, sample width in bits; must be ≤ SLOT_BITS.
- SLOT_BITS, 32, bit clocks per TDM slot; frame length is 4*SLOT_BITS (128 by default).

Ports:
- clk  in  1  bit clock (BICK); all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- lrck  in  1  frame clock from controller; low during slots 0–1, high during slots 2–3.
- sdin  in  1  serial DAC data from controller, MSB first.
- sdout  out  1  serial ADC data to controller, MSB first, registered.
- sample_in0..3  in  W each, signed  ADC words to transmit in slots 0..3.
- sample_out0..3  out  W each, signed  DAC words received in slots 0..3.
- sample_valid  out  1  one-cycle strobe; sample_out0..3 updated this cycle.
- locked  out  1  framing locked.
- sync_err  out  1  one-cycle strobe on an unexpected LRCK edge.

Behaviour:
- Reset (async): sample_out0..3 = 0, sdout = 0, sample_valid = 0, locked = 0, sync_err = 0; position counter, shift register, rx/tx buffers, lrck_prev = 0.
- lrck_prev registers lrck each posedge.
- Fall edge: lrck_prev = 1 and lrck = 0. Rise edge: lrck_prev = 0 and lrck = 1.
- Position p (0..4*SLOT_BITS-1):
  - p = 0 on the cycle a fall edge is seen; otherwise p increments and wraps modulo frame length.
  - slot s = p / SLOT_BITS; bit b = p mod SLOT_BITS.
- Lock rules:
  - Fall edge while unlocked and p == frame length - 1 (i.e. one full frame after the previous fall) → locked = 1. Otherwise the counter resyncs with locked = 0.
  - While locked, a fall edge at p ≠ 0, a rise edge at p ≠ 2*SLOT_BITS, or a missing fall edge at wrap → locked = 0 and one-cycle sync_err.
  - On a mis-timed fall edge the counter resyncs to p = 0.
  - The first fall edge after reset never sets locked and never raises sync_err.
- Receive:
  - For b in 0..W-1, sdin is shifted into an rx shift register at posedge (MSB at b = 0).
  - At b = W-1 the completed word (including the current bit) is written to rx_buf[s].
  - Bits b ≥ W are ignored.
- Frame commit at p = frame length - 1, only when locked:
  - sample_out0..3 <= rx_buf[0..3]; sample_valid = 1 for that cycle.
  - tx_buf[0..3] <= sample_in0..3 (sampled that cycle) for transmission in the next frame.
  - When unlocked: no commit, sample_valid stays 0, outputs hold.
- Transmit:
  - sdout is registered so that during position p it carries tx_buf[s][W-1-b] for b < W, else 0.
  - The value is loaded at the posedge ending position p-1; the load at p = frame length - 1 uses the new tx_buf MSB for slot 0.
  - sdout = 0 whenever locked = 0.
- Latency: the word in sample_in at commit appears on SDOUT 1..SLOT_BITS*4 cycles later. A DAC word completes at p = s*SLOT_BITS+W-1 and is presented at the next commit.
- Loss of lock mid-frame: partial rx_buf contents are kept but not committed; sdout forced to 0 from the next cycle.
- Reset mid-frame: immediate return to reset state, relock required.

Optional Feature:
- AK4619_TARGET_LOOPBACK_EN.
- Defined: at commit, tx_buf[i] <= rx_buf[i] (received DAC words echo back on SDOUT next frame) and sample_in0..3 are ignored.
- Undefined: tx_buf is loaded from sample_in0..3 as above.

Test Plan:
- Reset, then periodic LRCK (64 low / 64 high), 3 frames → locked rises at the 2nd fall edge, first sample_valid at p=127 of that frame, sync_err never pulses.
- Locked; controller sends slots 0x1234, 0x8000, 0x7FFF, 0xFFFF → sample_out0..3 equal those values on the next sample_valid.
- sample_in0..3 = 0xA5A5, 0x0001, 0x8000, 0x5A5A held across commit → next frame SDOUT shows these MSB-first at p=0..15, 32..47, 64..79, 96..111, and 0 elsewhere.
- Locked, inject a fall edge at p=50 → sync_err 1 cycle, locked=0, sdout=0, no sample_valid. A clean frame afterwards relocks.
- Assert rst at p=20 → all outputs 0 immediately; lock reacquired after 2 fall edges.
- With AK4619_TARGET_LOOPBACK_EN: send 0x0F0F, 0xF0F0, 0x1111, 0xEEEE → the same words appear on SDOUT in the following frame.
